// File: rtl/cpu_player_pkg.sv
// Shared state encoding and helpers for the SubtractSquare CPU opponent.
package cpu_player_pkg;

    typedef enum logic [2:0] {
        BUILD,
        IDLE,
        SEARCH,
        DRIVE,
        RELEASE
    } state_t;

    localparam int MAX_ROOT = 15;

    function automatic logic [7:0] root_sq(input logic [3:0] k);
        logic [7:0] kk;
        kk = {4'b0000, k};
        return kk * kk;
    endfunction

endpackage

// File: rtl/cpu_player_losing_table.sv
// 256x1 losing-position table: one synchronous write port, one combinational read port.
module losing_table (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic       wdata_i,
    input  logic [7:0] raddr_i,
    output logic       rdata_o
);

    // Contents are not reset; every entry is rewritten by BUILD before it is read.
    logic [255:0] mem_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_player.sv
// CPU opponent: builds the losing table after reset, then answers move requests
// with a winning root (or the largest legal root) and a load_input high/low pulse.
module cpu_player #(
    parameter int PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_req,
    input  logic [7:0] game_state,
    output logic [3:0] player_input,
    output logic       load_input,
    output logic       busy,
    output logic       table_ready,
    output logic       no_move
);
    import cpu_player_pkg::*;

    localparam logic [7:0] LAST_CNT = 8'(PULSE_CYCLES - 1);

    state_t     state_q;
    logic [7:0] n_q;
    logic [4:0] k_q;
    logic [7:0] s_q;
    logic [7:0] cnt_q;
    logic       pending_q;
    logic [7:0] pend_state_q;
    logic [3:0] player_input_q;
    logic       load_q;
    logic       busy_q;
    logic       ready_q;
    logic       no_move_q;

    logic [7:0] cur_x;
    logic [7:0] sq;
    logic [7:0] rd_addr;
    logic       too_big;
    logic       lose_rd;
    logic       build_end;
    logic       tbl_wdata;
    logic       req_any;
    logic [7:0] req_state;

    // One table lookup serves both BUILD (position n) and SEARCH (position s).
    assign cur_x     = (state_q == BUILD) ? n_q : s_q;
    assign sq        = root_sq(k_q[3:0]);
    assign too_big   = k_q[4] | (sq > cur_x);
    assign rd_addr   = cur_x - sq;
    assign build_end = (state_q == BUILD) && (k_q != 5'd0) &&
                       (too_big || lose_rd || (k_q == 5'(MAX_ROOT)));
    assign tbl_wdata = too_big | ~lose_rd;
    assign req_any   = move_req | pending_q;
    assign req_state = move_req ? game_state : pend_state_q;

    losing_table u_table (
        .clk     (clk),
        .we_i    (build_end),
        .waddr_i (n_q),
        .wdata_i (tbl_wdata),
        .raddr_i (rd_addr),
        .rdata_o (lose_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= BUILD;
            n_q            <= 8'd0;
            k_q            <= 5'd0;
            s_q            <= 8'd0;
            cnt_q          <= 8'd0;
            pending_q      <= 1'b0;
            pend_state_q   <= 8'd0;
            player_input_q <= 4'd0;
            load_q         <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
            no_move_q      <= 1'b0;
        end else begin
            no_move_q <= 1'b0;
            case (state_q)
                BUILD: begin
                    if (move_req) begin
                        pending_q    <= 1'b1;
                        pend_state_q <= game_state;
                    end
                    if (build_end) begin
                        k_q <= 5'd1;
                        if (n_q == 8'hFF) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            n_q <= n_q + 8'd1;
                        end
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                IDLE: begin
                    if (req_any) begin
                        pending_q <= 1'b0;
                        if (req_state == 8'd0) begin
                            no_move_q <= 1'b1;
                        end else begin
                            s_q     <= req_state;
                            k_q     <= 5'd1;
                            busy_q  <= 1'b1;
                            state_q <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // Roots are tried in ascending order, so k-1 is the largest legal root.
                    if (too_big) begin
                        player_input_q <= 4'(k_q - 5'd1);
                        load_q         <= 1'b1;
                        cnt_q          <= 8'd0;
                        state_q        <= DRIVE;
                    end else if (lose_rd) begin
                        player_input_q <= k_q[3:0];
                        load_q         <= 1'b1;
                        cnt_q          <= 8'd0;
                        state_q        <= DRIVE;
                    end else begin
                        k_q <= k_q + 5'd1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == LAST_CNT) begin
                        load_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == LAST_CNT) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= BUILD;
            endcase
        end
    end

    assign player_input = player_input_q;
    assign load_input   = load_q;
    assign busy         = busy_q;
    assign table_ready  = ready_q;
    assign no_move      = no_move_q;

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: hand vectors, a losing-range sweep,
// random states against a reference model, and reset/pending corner cases.
module tb_cpu_player;

    localparam int PULSE = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       move_req = 1'b0;
    logic [7:0] game_state = 8'd0;
    logic [3:0] player_input;
    logic       load_input;
    logic       busy;
    logic       table_ready;
    logic       no_move;

    int total  = 0;
    int passed = 0;
    int lose_m[256];

    typedef struct {
        int s;
        int k;
        bit nm;
    } vec_t;

    vec_t vecs[14];

    cpu_player #(.PULSE_CYCLES(PULSE)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .move_req     (move_req),
        .game_state   (game_state),
        .player_input (player_input),
        .load_input   (load_input),
        .busy         (busy),
        .table_ready  (table_ready),
        .no_move      (no_move)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: subtraction game theory computed directly from the rules.
    function automatic void build_model();
        for (int n = 0; n < 256; n++) begin
            lose_m[n] = 1;
            for (int k = 1; k <= 15; k++)
                if (k * k <= n && lose_m[n - k * k] == 1) lose_m[n] = 0;
        end
    endfunction

    function automatic int model_k(input int s);
        int best;
        best = 0;
        for (int k = 1; k <= 15; k++)
            if (k * k <= s && lose_m[s - k * k] == 1) return k;
        for (int k = 1; k <= 15; k++)
            if (k * k <= s) best = k;
        return best;
    endfunction

    task automatic issue(input int s);
        @(negedge clk);
        move_req   = 1'b1;
        game_state = 8'(s);
    endtask

    task automatic observe(input string name, input int exp_k, input bit exp_nm, input int extra_at);
        int hi, rises, lows, busy_cnt, nm_cnt, k_seen;
        bit prev, fell, last_busy;
        int last_pi;
        hi = 0; rises = 0; lows = 0; busy_cnt = 0; nm_cnt = 0; k_seen = -1;
        prev = 0; fell = 0; last_busy = 0; last_pi = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load_input && !prev) begin
                rises++;
                k_seen = int'(player_input);
            end
            if (load_input) hi++;
            if (!load_input && prev) fell = 1;
            if (fell && busy && !load_input) lows++;
            if (busy) busy_cnt++;
            if (no_move) nm_cnt++;
            prev      = load_input;
            last_busy = busy;
            last_pi   = int'(player_input);
            move_req   = (i == extra_at);
            game_state = 8'($urandom);
        end
        move_req = 1'b0;
        if (exp_nm) begin
            check({name, "_nomove_pulses"}, nm_cnt, 1);
            check({name, "_load_high"}, hi, 0);
            check({name, "_busy_cycles"}, busy_cnt, 0);
        end else begin
            check({name, "_load_rises"}, rises, 1);
            check({name, "_k"}, k_seen, exp_k);
            check({name, "_high_cycles"}, hi, PULSE);
            check({name, "_low_cycles"}, lows, PULSE);
            check({name, "_busy_end"}, int'(last_busy), 0);
            check({name, "_k_held"}, last_pi, exp_k);
            check({name, "_nomove"}, nm_cnt, 0);
        end
    endtask

    task automatic wait_ready(input string name);
        int c;
        c = 0;
        while (table_ready !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(table_ready === 1'b1), 1);
    endtask

    initial begin
        int s;
        int c;
        build_model();
        vecs[0]  = '{30, 5, 0};
        vecs[1]  = '{4, 2, 0};
        vecs[2]  = '{11, 1, 0};
        vecs[3]  = '{3, 1, 0};
        vecs[4]  = '{10, 3, 0};
        vecs[5]  = '{0, 0, 1};
        vecs[6]  = '{2, 1, 0};
        vecs[7]  = '{44, 6, 0};
        vecs[8]  = '{17, 4, 0};
        vecs[9]  = '{39, 6, 0};
        vecs[10] = '{6, 1, 0};
        vecs[11] = '{9, 2, 0};
        vecs[12] = '{35, 1, 0};
        vecs[13] = '{26, 2, 0};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_player_input", int'(player_input), 0);
        check("rst_load_input", int'(load_input), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_table_ready", int'(table_ready), 0);
        check("rst_no_move", int'(no_move), 0);
        reset_n = 1'b1;

        // Requests during BUILD: the later one overwrites the latched state.
        issue(5);
        issue(8);
        @(negedge clk);
        move_req = 1'b0;
        check("build_busy", int'(busy), 0);
        check("build_not_ready", int'(table_ready), 0);
        wait_ready("table_ready_rise");
        observe("pending", 1, 0, 6);
        check("ready_stays", int'(table_ready), 1);

        foreach (vecs[i]) begin
            issue(vecs[i].s);
            observe($sformatf("vec_s%0d", vecs[i].s), vecs[i].k, vecs[i].nm,
                    vecs[i].nm ? -1 : 6);
        end

        for (int n = 1; n <= 44; n++) begin
            issue(n);
            observe($sformatf("sweep_s%0d", n), model_k(n), 0, -1);
        end

        for (int r = 0; r < 20; r++) begin
            s = int'($urandom_range(0, 255));
            issue(s);
            observe($sformatf("rand_s%0d", s), model_k(s), s == 0, (s == 0) ? -1 : 5);
        end

        // Reset while load_input is high.
        issue(30);
        @(negedge clk);
        move_req = 1'b0;
        c = 0;
        while (load_input !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("drive_reached", int'(load_input === 1'b1), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_load", int'(load_input), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(table_ready), 0);
        check("midrst_player_input", int'(player_input), 0);
        reset_n = 1'b1;
        c = 0;
        repeat (3) begin
            @(negedge clk);
            if (load_input !== 1'b0) c++;
        end
        check("postrst_no_pulse", c, 0);
        check("postrst_ready", int'(table_ready), 0);
        wait_ready("table_ready_rebuild");
        issue(30);
        observe("after_rebuild", 5, 0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Automated opponent for SubtractSquare. It is the producer side of the player_input/load_input interface that single_move consumes.
- After reset it builds a 256-entry losing-position table by dynamic programming.
- On each move request it searches for a winning root k (1..15). It then presents k on player_input and emits a load_input high-then-low pulse, which the move FSM needs to register one input.
- Sits beside single_move. A top-level mux selects human or cpu_player per turn.

Parameters:
- PULSE_CYCLES, 4: cycles load_input is held high, and then held low, per move. Legal range 1..255.
- MAX_ROOT, 15: largest root searched. It is fixed by the 4-bit player_input.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- move_req  in  1  one-cycle pulse: the CPU's turn has started
- game_state  in  8  current game state, sampled on move_req
- player_input  out  4  chosen root k
- load_input  out  1  load strobe toward the move FSM
- busy  out  1  high from accepted request until the pulse ends
- table_ready  out  1  high once the losing table is built
- no_move  out  1  one-cycle pulse: request made with game_state==0

Behaviour:
- Reset values (reset_n low at a clk edge): state=BUILD, player_input=0, load_input=0, busy=0, table_ready=0, no_move=0, pending=0, and all internal counters 0. Reset mid-operation aborts immediately, with no partial pulse after reset.
- Losing table: lose[n] is 1 iff no k in 1..15 exists with k*k<=n and lose[n-k*k]==1. lose[0]=1.
- BUILD state:
  - Outer n runs 0..255; inner k runs 1..15, one k per cycle.
  - Inner loop terminates early when k*k>n or a winning k is found.
  - lose[n] is written at the end of its inner loop.
  - After n=255 is written, go to IDLE and set table_ready=1. table_ready stays 1 until reset.
- Arithmetic: k*k is 8 bits, max 225. Compare k*k<=n before computing n-k*k, so no underflow occurs.
- move_req during BUILD: latch pending=1 and game_state. Serve the request on entry to IDLE, one cycle after table_ready rises. Later requests during BUILD overwrite the latched state.
- IDLE:
  - On move_req (or pending), latch s=game_state.
  - If s==0: pulse no_move for 1 cycle and stay IDLE; busy stays 0.
  - Otherwise set busy=1 and go to SEARCH with k=1.
- SEARCH (one k per cycle):
  - If k*k>s or k>15, no winning move exists. Choose fallback = largest k with k*k<=s and go to DRIVE.
  - Else if lose[s-k*k]==1, choose k and go to DRIVE.
  - Else increment k.
  - Worst-case latency: 16 cycles from request to DRIVE.
- DRIVE: player_input=chosen k, load_input=1 for PULSE_CYCLES cycles, then go to RELEASE.
- RELEASE: load_input=0 for PULSE_CYCLES cycles. Then busy=0 and return to IDLE.
- player_input holds its value through DRIVE and RELEASE, and after RELEASE until the next choice.
- move_req while busy=1 is ignored, not queued.
- game_state changes after sampling have no effect on the current move.

Decomposition:
- Package cpu_player_pkg holds:
  - state encoding constants BUILD, IDLE, SEARCH, DRIVE, RELEASE;
  - MAX_ROOT=15;
  - a square-of-root function (4-bit to 8-bit).
- One sub-module, losing_table: a 256x1 register array with one synchronous write port and one combinational read port, written only in BUILD.

Test Plan:
- Reset then wait: table_ready rises. Read-back gives lose=1 exactly at 0,2,5,7,10,12,15,17,20,22,34,39,44 within 0..44.
- move_req with game_state=30 -> player_input=5 (30-25=5 is losing). Exactly one load_input high pulse of 4 cycles followed by 4 low cycles; busy falls after.
- game_state=4 -> k=2; game_state=11 -> k=1; game_state=3 -> k=1.
- game_state=10 (losing) -> fallback k=3. game_state=0 -> no_move pulses once; load_input stays 0 and busy stays 0.
- move_req with game_state=8 asserted during BUILD -> served after table_ready with k=1. A second move_req while busy produces no second pulse.
- reset_n low during DRIVE -> load_input=0 next cycle; BUILD restarts and table_ready=0.
